// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp encodings, fault codes and the legal colour-step rule
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        NONE         = 3'd0,
        ILLEGAL_ENC  = 3'd1,
        CONFLICT     = 3'd2,
        BAD_SEQ      = 3'd3,
        SHORT_YELLOW = 3'd4,
        LONG_YELLOW  = 3'd5
    } fault_code_t;

    function automatic logic step_ok(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || (p == RED && c == GREEN) || (p == GREEN && c == YELLOW) ||
               (p == YELLOW && c == RED);
    endfunction

endpackage

// File: rtl/light_channel_checker.sv
// light_channel_checker: per-lamp sample history, yellow run length and fault flags
module light_channel_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 6,
    parameter int MAX_YELLOW = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] light,
    output logic [2:0] cur,
    output logic       enc_err,
    output logic       seq_err,
    output logic       short_y,
    output logic       long_y
);

    localparam logic [CNT_W-1:0] YSAT = CNT_W'(MAX_YELLOW + 1);
    localparam logic [CNT_W-1:0] YMIN = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] YMAX = CNT_W'(MAX_YELLOW);

    logic [2:0]       prev;
    logic [CNT_W-1:0] ycnt;

    // sample the lamp, keep one sample of history and the saturating yellow run length
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cur  <= RED;
            prev <= RED;
            ycnt <= '0;
        end else begin
            cur  <= light;
            prev <= cur;
            ycnt <= (cur == YELLOW) ? ((ycnt >= YSAT) ? YSAT : ycnt + 1'b1) : '0;
        end

    // classify the current sample; a bad encoding masks the sequence and timing checks
    always_comb begin
        enc_err = !(cur inside {RED, YELLOW, GREEN});
        seq_err = !enc_err && !step_ok(prev, cur);
        short_y = !enc_err && prev == YELLOW && cur == RED && ycnt < YMIN;
        long_y  = !enc_err && cur == YELLOW && ycnt >= YMAX;
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks both lamps and latches the first fault with its code
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 6,
    parameter int MAX_YELLOW = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] la,
    input  logic [2:0] lb,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_chan
);

    logic [2:0]  a_cur, b_cur;
    logic        a_enc, a_seq, a_sy, a_ly;
    logic        b_enc, b_seq, b_sy, b_ly;
    logic        conflict, det_chan;
    fault_code_t det_code;

    light_channel_checker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .CNT_W(CNT_W)) u_a (
        .clk(clk), .reset_n(reset_n), .light(la), .cur(a_cur),
        .enc_err(a_enc), .seq_err(a_seq), .short_y(a_sy), .long_y(a_ly)
    );

    light_channel_checker #(.MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW), .CNT_W(CNT_W)) u_b (
        .clk(clk), .reset_n(reset_n), .light(lb), .cur(b_cur),
        .enc_err(b_enc), .seq_err(b_seq), .short_y(b_sy), .long_y(b_ly)
    );

    // lowest code wins, channel A wins ties; conflict is reported on channel A
    always_comb begin
        conflict = a_cur != RED && b_cur != RED;
        det_code = (a_enc || b_enc) ? ILLEGAL_ENC :
                   conflict         ? CONFLICT    :
                   (a_seq || b_seq) ? BAD_SEQ     :
                   (a_sy || b_sy)   ? SHORT_YELLOW :
                   (a_ly || b_ly)   ? LONG_YELLOW : NONE;
        det_chan = a_enc ? 1'b0 : b_enc ? 1'b1 : conflict ? 1'b0 :
                   a_seq ? 1'b0 : b_seq ? 1'b1 : a_sy ? 1'b0 : b_sy ? 1'b1 :
                   a_ly  ? 1'b0 : b_ly;
    end

    // hold the first fault; a detection on a clear edge is captured instead of clearing
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            fault      <= 1'b0;
            fault_code <= 3'd0;
            fault_chan <= 1'b0;
        end else if (det_code != NONE && (!fault || fault_clr)) begin
            fault      <= 1'b1;
            fault_code <= det_code;
            fault_chan <= det_chan;
        end else if (fault_clr) begin
            fault      <= 1'b0;
            fault_code <= 3'd0;
            fault_chan <= 1'b0;
        end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Independent lamp-side monitor for the two-road intersection controller. Consumes the {Red, Yellow, Green} light vectors the controller drives to Academic (A) and Bravado (B). Checks every cycle for illegal encodings, conflicting greens, illegal colour sequences and out-of-range yellow durations. Latches the first fault with a code, so the board can force all-red flashing.

## Interface
- MIN_YELLOW, 6: minimum legal consecutive yellow cycles per channel.
- MAX_YELLOW, 16: maximum legal consecutive yellow cycles; must be > MIN_YELLOW.
- CNT_W, 5: yellow counter width; must hold MAX_YELLOW+1.
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- la  input  3  Academic light {R,Y,G}.
- lb  input  3  Bravado light {R,Y,G}.
- fault_clr  input  1  synchronous clear of latched fault.
- fault  output  1  sticky fault flag.
- fault_code  output  3  code of first captured fault; 0 = none.
- fault_chan  output  1  channel of captured fault: 0 = A, 1 = B; 0 for conflict.

## Operation
- Legal values are RED=100, YELLOW=010 and GREEN=001.
- Each channel registers its input to cur, then copies cur to prev on the next edge.
- Yellow counter ycnt: if cur==YELLOW, ycnt <= min(ycnt+1, MAX_YELLOW+1); otherwise ycnt <= 0.
- ycnt counts the consecutive yellow samples ending at prev.
- Detected conditions, all evaluated combinationally from cur/prev/ycnt:
  - 1 ILLEGAL_ENC: cur is not one of the three legal values. When this fires, checks 3–5 are suppressed for that channel.
  - 2 CONFLICT: la cur != RED and lb cur != RED in the same cycle.
  - 3 BAD_SEQ: prev→cur is not in the legal set {R→R, R→G, G→G, G→Y, Y→Y, Y→R}. This makes G→R, Y→G and R→Y illegal.
  - 4 SHORT_YELLOW: prev==Y, cur==R and ycnt < MIN_YELLOW.
  - 5 LONG_YELLOW: cur==Y and ycnt >= MAX_YELLOW.
- Priority on simultaneous detection: lowest code wins; for equal codes, A wins over B.
- Capture: when fault==0 and any condition is detected, the next edge sets fault=1 and loads fault_code/fault_chan.
- While fault==1, further detections are ignored (first fault retained).
- fault_clr==1 at an edge clears fault, fault_code and fault_chan.
  - If a detection is present at that same edge, the new fault is captured instead (detection beats clear).
- Checking continues while faulted so that prev/ycnt stay coherent; only capture is blocked.

## Timing
- Reset values:
  - fault=0, fault_code=0, fault_chan=0.
  - cur and prev of both channels = RED; both ycnt = 0.
- Latency: an offending value sampled into cur at edge E shows as fault=1 after edge E+1, i.e. 2 edges after it appears on la/lb.
- Yellow timing, for MIN_YELLOW=6:
  - exactly 6 yellow samples followed by red is legal;
  - 5 yellow samples followed by red gives code 4.
- Long yellow, for MAX_YELLOW=16: the 17th consecutive yellow sample triggers code 5.
- ycnt saturates at MAX_YELLOW+1 and never wraps.
- Reset mid-operation: asynchronous assertion clears all state immediately.
  - The first post-reset sample is compared against prev=RED, so a post-reset GREEN is legal and a post-reset YELLOW is BAD_SEQ.
- fault_clr held high continuously: fault still rises on any detection (detection priority) and falls on the next clean edge.

## Structure
- Shared package traffic_pkg holds:
  - light encodings RED, YELLOW, GREEN (3-bit localparams);
  - fault_code_t enum: NONE=0, ILLEGAL_ENC=1, CONFLICT=2, BAD_SEQ=3, SHORT_YELLOW=4, LONG_YELLOW=5.
- Sub-module light_channel_checker, instanced once per channel:
  - contains the cur/prev registers and the ycnt counter;
  - outputs cur plus per-channel flags enc_err, seq_err, short_y, long_y.
- Top level computes CONFLICT from both cur values, applies priority, and owns the fault capture register.

## Test plan
- Normal cycle: A G×10, Y×6, R while B R; then B G×10, Y×6, R; repeated 3 times → fault stays 0.
- Conflict: drive la=001, lb=001 for one cycle from a clean R/G state → fault=1, fault_code=2, fault_chan=0, two edges later.
- Short yellow: A G×4, Y×5, R → fault_code=4, fault_chan=0. Same test with Y×6 → no fault. Same test with Y×17 → fault_code=5.
- Illegal encoding and priority: lb=011 while A G→R in the same cycle → fault_code=1, fault_chan=1 (beats BAD_SEQ on A).
- First-fault retention and clear:
  - BAD_SEQ on A (Y→G), then conflict 3 cycles later → code stays 3.
  - Pulse fault_clr with clean inputs → fault=0, code=0 one edge later.
  - Assert fault_clr on the same edge as a new conflict → code=2.
- Async reset: assert reset_n=0 mid-yellow on A → outputs 0 immediately, without a clock edge. Release reset, then drive A=Y → fault_code=3.
